// File: rtl/riscp_pkg.sv
// Shared types and widths for the MEM/WB write-back slice.
package riscp_pkg;

  localparam int DATA_W = 16;
  localparam int PC_W   = 32;

  typedef enum logic [1:0] {
    WB_ALU    = 2'b00,
    WB_MEM    = 2'b01,
    WB_INPORT = 2'b10,
    WB_ZERO   = 2'b11
  } wb_sel_e;

  typedef enum logic {
    PC_IDLE,
    PC_HAVE_HI
  } pc_fsm_e;

endpackage

// File: rtl/writeback_stage_pc_assembler.sv
// Rebuilds a PC from two popped stack words: high half first, then low half.
module pc_assembler #(
  parameter int DATA_W = riscp_pkg::DATA_W,
  parameter int PC_W   = riscp_pkg::PC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_half_vld,
  output logic [PC_W-1:0]   o_pc,
  output logic              o_pc_vld
);
  import riscp_pkg::*;

  pc_fsm_e           r_state;
  pc_fsm_e           w_state_nxt;
  logic              w_take_hi;
  logic              w_complete;
  logic [DATA_W-1:0] r_hi;
  logic [PC_W-1:0]   r_pc;
  logic              r_pc_vld;

  // State register; reset mid-sequence forgets any held high half.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= PC_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: only PC-half slots move the FSM; gaps of any length hold it.
  always_comb begin
    w_state_nxt = r_state;
    w_take_hi   = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      PC_IDLE: begin
        if (i_half_vld) begin
          w_take_hi   = 1'b1;
          w_state_nxt = PC_HAVE_HI;
        end
      end
      PC_HAVE_HI: begin
        if (i_half_vld) begin
          w_complete  = 1'b1;
          w_state_nxt = PC_IDLE;
        end
      end
      default: w_state_nxt = PC_IDLE;
    endcase
  end

  // High-half holding register, PC output register and its one-cycle valid pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi     <= '0;
      r_pc     <= '0;
      r_pc_vld <= 1'b0;
    end else begin
      if (w_take_hi)  r_hi <= i_word;
      if (w_complete) r_pc <= {r_hi, i_word};
      r_pc_vld <= w_complete;
    end
  end

  assign o_pc     = r_pc;
  assign o_pc_vld = r_pc_vld;

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, write-back mux, output-port register and PC reassembly.
module writeback_stage #(
  parameter int DATA_W     = riscp_pkg::DATA_W,
  parameter int PC_W       = riscp_pkg::PC_W,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_wb,
  input  logic                  reg_write_m,
  input  logic [1:0]            wb_sel_m,
  input  logic [REG_ADDR_W-1:0] reg_write_address_m,
  input  logic [DATA_W-1:0]     alu_result_m,
  input  logic [DATA_W-1:0]     mem_data_m,
  input  logic [DATA_W-1:0]     inport_data,
  input  logic                  outport_enable_m,
  input  logic                  mem_pop_m,
  input  logic                  pc_choose_memory_m,
  output logic                  reg_write_wb,
  output logic [REG_ADDR_W-1:0] reg_write_address_from_wb,
  output logic [DATA_W-1:0]     reg_write_data_from_wb,
  output logic [DATA_W-1:0]     outport_data,
  output logic [PC_W-1:0]       pc_from_memory,
  output logic                  pc_load_valid
);
  import riscp_pkg::*;

  logic                  r_reg_write_p0;
  wb_sel_e               r_wb_sel_p0;
  logic [REG_ADDR_W-1:0] r_addr_p0;
  logic [DATA_W-1:0]     r_alu_p0;
  logic [DATA_W-1:0]     r_mem_p0;
  logic [DATA_W-1:0]     r_inport_p0;
  logic                  r_outen_p0;
  logic                  r_pop_p0;
  logic                  r_pcsel_p0;
  logic [DATA_W-1:0]     r_outport;
  logic                  w_pc_half;

  function automatic logic [DATA_W-1:0] wb_select(
    input wb_sel_e           sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem,
    input logic [DATA_W-1:0] inp
  );
    case (sel)
      WB_ALU:    return alu;
      WB_MEM:    return mem;
      WB_INPORT: return inp;
      default:   return '0;
    endcase
  endfunction

  // MEM/WB capture; a flush turns the slot into a bubble but keeps the data fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write_p0 <= 1'b0;
      r_wb_sel_p0    <= WB_ALU;
      r_addr_p0      <= '0;
      r_alu_p0       <= '0;
      r_mem_p0       <= '0;
      r_inport_p0    <= '0;
      r_outen_p0     <= 1'b0;
      r_pop_p0       <= 1'b0;
      r_pcsel_p0     <= 1'b0;
    end else begin
      r_reg_write_p0 <= reg_write_m        & ~flush_wb;
      r_wb_sel_p0    <= flush_wb ? WB_ALU : wb_sel_e'(wb_sel_m);
      r_outen_p0     <= outport_enable_m   & ~flush_wb;
      r_pop_p0       <= mem_pop_m          & ~flush_wb;
      r_pcsel_p0     <= pc_choose_memory_m & ~flush_wb;
      r_addr_p0      <= reg_write_address_m;
      r_alu_p0       <= alu_result_m;
      r_mem_p0       <= mem_data_m;
      r_inport_p0    <= inport_data;
    end
  end

  // Output-port register follows the ALU field of an OUT slot, otherwise holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_outport <= '0;
    else if (r_outen_p0) r_outport <= r_alu_p0;
  end

  // ---- WB stage: register-file write port straight off the MEM/WB flops ----
  assign reg_write_wb              = r_reg_write_p0;
  assign reg_write_address_from_wb = r_addr_p0;
  assign reg_write_data_from_wb    = wb_select(r_wb_sel_p0, r_alu_p0, r_mem_p0, r_inport_p0);
  assign outport_data              = r_outport;

  assign w_pc_half = r_pop_p0 & r_pcsel_p0;

  pc_assembler #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W)
  ) u_pc_assembler (
    .clk        (clk),
    .reset      (reset),
    .i_word     (r_mem_p0),
    .i_half_vld (w_pc_half),
    .o_pc       (pc_from_memory),
    .o_pc_vld   (pc_load_valid)
  );

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with immediate-assertion checks.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_wb;
  logic        reg_write_m;
  logic [1:0]  wb_sel_m;
  logic [2:0]  reg_write_address_m;
  logic [15:0] alu_result_m;
  logic [15:0] mem_data_m;
  logic [15:0] inport_data;
  logic        outport_enable_m;
  logic        mem_pop_m;
  logic        pc_choose_memory_m;
  logic        reg_write_wb;
  logic [2:0]  reg_write_address_from_wb;
  logic [15:0] reg_write_data_from_wb;
  logic [15:0] outport_data;
  logic [31:0] pc_from_memory;
  logic        pc_load_valid;

  int checks = 0;
  int errors = 0;

  writeback_stage dut (
    .clk                       (clk),
    .reset                     (reset),
    .flush_wb                  (flush_wb),
    .reg_write_m               (reg_write_m),
    .wb_sel_m                  (wb_sel_m),
    .reg_write_address_m       (reg_write_address_m),
    .alu_result_m              (alu_result_m),
    .mem_data_m                (mem_data_m),
    .inport_data               (inport_data),
    .outport_enable_m          (outport_enable_m),
    .mem_pop_m                 (mem_pop_m),
    .pc_choose_memory_m        (pc_choose_memory_m),
    .reg_write_wb              (reg_write_wb),
    .reg_write_address_from_wb (reg_write_address_from_wb),
    .reg_write_data_from_wb    (reg_write_data_from_wb),
    .outport_data              (outport_data),
    .pc_from_memory            (pc_from_memory),
    .pc_load_valid             (pc_load_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush_wb            = 1'b0;
    reg_write_m         = 1'b0;
    wb_sel_m            = 2'b00;
    reg_write_address_m = 3'd0;
    alu_result_m        = 16'h0000;
    mem_data_m          = 16'h0000;
    inport_data         = 16'h0000;
    outport_enable_m    = 1'b0;
    mem_pop_m           = 1'b0;
    pc_choose_memory_m  = 1'b0;
  endtask

  task automatic pc_half(input logic [15:0] w);
    clr();
    mem_pop_m          = 1'b1;
    pc_choose_memory_m = 1'b1;
    mem_data_m         = w;
  endtask

  initial begin
    // Reset held low with every input active.
    reset               = 1'b0;
    flush_wb            = 1'b0;
    reg_write_m         = 1'b1;
    wb_sel_m            = 2'b01;
    reg_write_address_m = 3'd5;
    alu_result_m        = 16'h5555;
    mem_data_m          = 16'h7777;
    inport_data         = 16'h3333;
    outport_enable_m    = 1'b1;
    mem_pop_m           = 1'b1;
    pc_choose_memory_m  = 1'b1;
    step();
    step();
    chk("rst_regwrite", {31'd0, reg_write_wb}, 32'd0);
    chk("rst_addr",     {29'd0, reg_write_address_from_wb}, 32'd0);
    chk("rst_data",     {16'd0, reg_write_data_from_wb}, 32'd0);
    chk("rst_outport",  {16'd0, outport_data}, 32'd0);
    chk("rst_pc",       pc_from_memory, 32'd0);
    chk("rst_pcvld",    {31'd0, pc_load_valid}, 32'd0);

    clr();
    reset = 1'b1;
    // ALU write-back slot.
    reg_write_m         = 1'b1;
    reg_write_address_m = 3'd3;
    alu_result_m        = 16'h1234;
    step();
    chk("alu_regwrite", {31'd0, reg_write_wb}, 32'd1);
    chk("alu_addr",     {29'd0, reg_write_address_from_wb}, 32'd3);
    chk("alu_data",     {16'd0, reg_write_data_from_wb}, 32'h1234);
    chk("alu_outport",  {16'd0, outport_data}, 32'd0);

    // Write-back source selects.
    mem_data_m  = 16'hBEEF;
    inport_data = 16'h00AA;
    wb_sel_m    = 2'b01;
    step();
    chk("sel_mem",    {16'd0, reg_write_data_from_wb}, 32'hBEEF);
    wb_sel_m = 2'b10;
    step();
    chk("sel_inport", {16'd0, reg_write_data_from_wb}, 32'h00AA);
    wb_sel_m = 2'b11;
    step();
    chk("sel_zero",   {16'd0, reg_write_data_from_wb}, 32'h0000);
    chk("sel_zero_we", {31'd0, reg_write_wb}, 32'd1);

    // PC pair with three bubbles between the halves.
    pc_half(16'h0001);
    step();
    clr();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_pcvld", {31'd0, pc_load_valid}, 32'd0);
    end
    pc_half(16'h2345);
    step();
    chk("lo_in_wb_pcvld", {31'd0, pc_load_valid}, 32'd0);
    clr();
    step();
    chk("pair_pcvld", {31'd0, pc_load_valid}, 32'd1);
    chk("pair_pc",    pc_from_memory, 32'h0001_2345);
    step();
    chk("pair_pcvld_drop", {31'd0, pc_load_valid}, 32'd0);
    chk("pair_pc_hold",    pc_from_memory, 32'h0001_2345);

    // Known outport value before the flush test.
    clr();
    outport_enable_m = 1'b1;
    alu_result_m     = 16'h0077;
    step();
    clr();
    step();
    chk("out_preload", {16'd0, outport_data}, 32'h0077);

    // Flushed slot carrying write, OUT and a PC half.
    clr();
    flush_wb            = 1'b1;
    reg_write_m         = 1'b1;
    reg_write_address_m = 3'd6;
    outport_enable_m    = 1'b1;
    alu_result_m        = 16'h9999;
    mem_pop_m           = 1'b1;
    pc_choose_memory_m  = 1'b1;
    mem_data_m          = 16'h1111;
    step();
    chk("flush_regwrite", {31'd0, reg_write_wb}, 32'd0);
    chk("flush_addr_kept", {29'd0, reg_write_address_from_wb}, 32'd6);
    clr();
    step();
    chk("flush_outport", {16'd0, outport_data}, 32'h0077);
    chk("flush_pcvld",   {31'd0, pc_load_valid}, 32'd0);
    // FSM must still be idle: this pair completes on its own.
    pc_half(16'h0BAD);
    step();
    pc_half(16'hCAFE);
    step();
    clr();
    step();
    chk("flush_fsm_pcvld", {31'd0, pc_load_valid}, 32'd1);
    chk("flush_fsm_pc",    pc_from_memory, 32'h0BAD_CAFE);

    // Reset in the middle of a pair discards the held half.
    pc_half(16'hDEAD);
    step();
    clr();
    reset = 1'b0;
    #2;
    chk("midrst_pc",      pc_from_memory, 32'd0);
    chk("midrst_outport", {16'd0, outport_data}, 32'd0);
    reset = 1'b1;
    pc_half(16'hAAAA);
    step();
    pc_half(16'h5555);
    step();
    clr();
    step();
    chk("fresh_pcvld", {31'd0, pc_load_valid}, 32'd1);
    chk("fresh_pc",    pc_from_memory, 32'hAAAA_5555);

    // OUT slot then ordinary slots: outport loads once and holds.
    clr();
    outport_enable_m = 1'b1;
    alu_result_m     = 16'h00FF;
    step();
    chk("out_not_yet", {16'd0, outport_data}, 32'h0000);
    clr();
    alu_result_m = 16'h1111;
    step();
    chk("out_load", {16'd0, outport_data}, 32'h00FF);
    alu_result_m = 16'h2222;
    reg_write_m  = 1'b1;
    step();
    chk("out_hold1", {16'd0, outport_data}, 32'h00FF);
    step();
    chk("out_hold2", {16'd0, outport_data}, 32'h00FF);

    // Register write and PC half in the same slot.
    pc_half(16'h4321);
    reg_write_m         = 1'b1;
    wb_sel_m            = 2'b01;
    reg_write_address_m = 3'd7;
    step();
    chk("dual_regwrite", {31'd0, reg_write_wb}, 32'd1);
    chk("dual_data",     {16'd0, reg_write_data_from_wb}, 32'h4321);
    pc_half(16'h8765);
    step();
    clr();
    step();
    chk("dual_pc", pc_from_memory, 32'h4321_8765);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
